// File: rtl/branch_predict_pc.sv
// Fetch-address generator with a direct-mapped branch target buffer and 2-bit
// saturating direction counters, redirected by execute-stage branch resolution.
module branch_predict_pc #(
    parameter int                 ADDR_W    = 64,
    parameter int                 BTB_DEPTH = 16,
    parameter int                 CNT_W     = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    output logic [ADDR_W-1:0] pc,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              resolve_valid,
    input  logic              resolve_is_branch,
    input  logic              resolve_taken,
    input  logic [ADDR_W-1:0] resolve_pc,
    input  logic [ADDR_W-1:0] resolve_target,
    input  logic              resolve_pred_taken,
    input  logic [ADDR_W-1:0] resolve_pred_target,
    output logic              flush,
    output logic [CNT_W-1:0]  n_branch,
    output logic [CNT_W-1:0]  n_mispredict
);
    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(3'd4);

    function automatic logic [1:0] sat_cnt(input logic [1:0] cnt, input logic up);
        logic [1:0] res;
        if (up) begin
            res = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
        end else begin
            res = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
        end
        return res;
    endfunction

    logic              valid_r  [BTB_DEPTH];
    logic [TAG_W-1:0]  tag_r    [BTB_DEPTH];
    logic [ADDR_W-1:0] target_r [BTB_DEPTH];
    logic [1:0]        cnt_r    [BTB_DEPTH];

    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] next_pc_s;
    logic [CNT_W-1:0]  n_branch_r;
    logic [CNT_W-1:0]  n_mispredict_r;

    logic [IDX_W-1:0]  idx_s;
    logic [TAG_W-1:0]  tag_s;
    logic              pred_taken_s;
    logic [IDX_W-1:0]  r_idx_s;
    logic [TAG_W-1:0]  r_tag_s;
    logic              r_hit_s;
    logic              upd_s;
    logic              mispredict_s;

    assign idx_s        = pc_r[IDX_W+1:2];
    assign tag_s        = pc_r[ADDR_W-1:IDX_W+2];
    assign pred_taken_s = valid_r[idx_s] && (tag_r[idx_s] == tag_s) && cnt_r[idx_s][1];

    assign r_idx_s = resolve_pc[IDX_W+1:2];
    assign r_tag_s = resolve_pc[ADDR_W-1:IDX_W+2];
    assign r_hit_s = valid_r[r_idx_s] && (tag_r[r_idx_s] == r_tag_s);
    assign upd_s   = resolve_valid && resolve_is_branch;

    assign mispredict_s = resolve_valid &&
                          ((resolve_taken != resolve_pred_taken) ||
                           (resolve_taken && (resolve_target != resolve_pred_target)));

    assign pc           = pc_r;
    assign pred_taken   = pred_taken_s;
    assign pred_target  = pred_taken_s ? target_r[idx_s] : '0;
    assign flush        = mispredict_s;
    assign n_branch     = n_branch_r;
    assign n_mispredict = n_mispredict_r;

    // Next fetch address: a mispredict outranks stall, which outranks prediction.
    always_comb begin
        next_pc_s = pc_r;
        if (mispredict_s) begin
            if (resolve_taken) begin
                next_pc_s = resolve_target;
            end else begin
                next_pc_s = resolve_pc + PC_STEP;
            end
        end else if (stall) begin
            next_pc_s = pc_r;
        end else if (pred_taken_s) begin
            next_pc_s = target_r[idx_s];
        end else begin
            next_pc_s = pc_r + PC_STEP;
        end
    end

    // Fetch PC register and saturating performance counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_r           <= RESET_PC;
            n_branch_r     <= '0;
            n_mispredict_r <= '0;
        end else begin
            pc_r <= next_pc_s;
            if (upd_s && (n_branch_r != {CNT_W{1'b1}})) begin
                n_branch_r <= n_branch_r + CNT_W'(1'b1);
            end
            if (mispredict_s && (n_mispredict_r != {CNT_W{1'b1}})) begin
                n_mispredict_r <= n_mispredict_r + CNT_W'(1'b1);
            end
        end
    end

    // BTB training; lookups above see the pre-update contents for this cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= '0;
                target_r[i] <= '0;
                cnt_r[i]    <= 2'b00;
            end
        end else if (upd_s) begin
            if (r_hit_s) begin
                cnt_r[r_idx_s] <= sat_cnt(cnt_r[r_idx_s], resolve_taken);
                if (resolve_taken) begin
                    target_r[r_idx_s] <= resolve_target;
                end
            end else if (resolve_taken) begin
                valid_r[r_idx_s]  <= 1'b1;
                tag_r[r_idx_s]    <= r_tag_s;
                target_r[r_idx_s] <= resolve_target;
                cnt_r[r_idx_s]    <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_pc.sv
// Directed bench: a 64-bit instance for prediction/training/priority/reset and
// an 8-bit, 2-bit-counter instance for address wrap and counter saturation.
module tb_branch_predict_pc;
    logic        clk;
    logic        reset;

    logic        stall;
    logic [63:0] pc;
    logic        pred_taken;
    logic [63:0] pred_target;
    logic        rv, rib, rt, rpt;
    logic [63:0] rpc, rtgt, rptgt;
    logic        flush;
    logic [31:0] n_branch, n_mispredict;

    logic        stall2;
    logic [7:0]  pc2;
    logic        pred_taken2;
    logic [7:0]  pred_target2;
    logic        rv2, rib2, rt2, rpt2;
    logic [7:0]  rpc2, rtgt2, rptgt2;
    logic        flush2;
    logic [1:0]  n_branch2, n_mispredict2;

    int checks;
    int errors;

    branch_predict_pc #(.ADDR_W(64), .BTB_DEPTH(16), .CNT_W(32), .RESET_PC(64'h0)) dut (
        .clk(clk), .reset(reset), .stall(stall), .pc(pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .resolve_valid(rv), .resolve_is_branch(rib), .resolve_taken(rt),
        .resolve_pc(rpc), .resolve_target(rtgt),
        .resolve_pred_taken(rpt), .resolve_pred_target(rptgt),
        .flush(flush), .n_branch(n_branch), .n_mispredict(n_mispredict)
    );

    branch_predict_pc #(.ADDR_W(8), .BTB_DEPTH(16), .CNT_W(2), .RESET_PC(8'hFC)) dut_w (
        .clk(clk), .reset(reset), .stall(stall2), .pc(pc2),
        .pred_taken(pred_taken2), .pred_target(pred_target2),
        .resolve_valid(rv2), .resolve_is_branch(rib2), .resolve_taken(rt2),
        .resolve_pc(rpc2), .resolve_target(rtgt2),
        .resolve_pred_taken(rpt2), .resolve_pred_target(rptgt2),
        .flush(flush2), .n_branch(n_branch2), .n_mispredict(n_mispredict2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_resolve();
        rv = 1'b0; rib = 1'b0; rt = 1'b0; rpt = 1'b0;
        rpc = 64'h0; rtgt = 64'h0; rptgt = 64'h0;
    endtask

    // Resolve a non-branch that was predicted not-taken but jumps: pure redirect.
    task automatic redirect(input logic [63:0] tgt);
        rv = 1'b1; rib = 1'b0; rt = 1'b1; rpt = 1'b0;
        rpc = 64'h1000; rtgt = tgt; rptgt = 64'h0;
        step();
        idle_resolve();
    endtask

    task automatic resolve_br(input logic [63:0] bpc, input logic taken,
                              input logic [63:0] tgt, input logic ptaken,
                              input logic [63:0] ptgt);
        rv = 1'b1; rib = 1'b1; rt = taken; rpt = ptaken;
        rpc = bpc; rtgt = tgt; rptgt = ptgt;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        stall  = 1'b0;
        idle_resolve();
        stall2 = 1'b0; rv2 = 1'b0; rib2 = 1'b0; rt2 = 1'b0; rpt2 = 1'b0;
        rpc2 = 8'h0; rtgt2 = 8'h0; rptgt2 = 8'h0;

        #12;
        chk("rst_pc", pc, 64'h0);
        chk("rst_pred", {63'd0, pred_taken}, 64'd0);
        chk("rst_flush", {63'd0, flush}, 64'd0);
        chk("rst_nb", {32'd0, n_branch}, 64'd0);
        chk("rst_nm", {32'd0, n_mispredict}, 64'd0);
        chk("rst_pc2", {56'd0, pc2}, 64'hFC);
        reset = 1'b1;

        // Sequential fetch
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("seq_pc", pc, 64'(4 * i));
            chk("seq_pred", {63'd0, pred_taken}, 64'd0);
            if (i == 1) chk("wrap_pc2", {56'd0, pc2}, 64'h00);
        end

        // Allocate on a taken miss
        resolve_br(64'h40, 1'b1, 64'h100, 1'b0, 64'h0);
        #1;
        chk("alloc_flush", {63'd0, flush}, 64'd1);
        step();
        idle_resolve();
        chk("alloc_pc", pc, 64'h100);
        chk("alloc_nm", {32'd0, n_mispredict}, 64'd1);
        chk("alloc_nb", {32'd0, n_branch}, 64'd1);

        // Predict from the new entry
        redirect(64'h40);
        chk("redir_pc", pc, 64'h40);
        chk("pred_hit", {63'd0, pred_taken}, 64'd1);
        chk("pred_tgt", pred_target, 64'h100);
        step();
        chk("pred_next_pc", pc, 64'h100);

        // Counter training while stalled at 0x40: 10 -> 11 -> 11 -> 10 -> 01
        redirect(64'h40);
        stall = 1'b1;
        resolve_br(64'h40, 1'b1, 64'h100, 1'b1, 64'h100);
        #1;
        chk("train_noflush", {63'd0, flush}, 64'd0);
        step();
        chk("stall_pc", pc, 64'h40);
        resolve_br(64'h40, 1'b1, 64'h100, 1'b1, 64'h100);
        step();
        resolve_br(64'h40, 1'b0, 64'h100, 1'b0, 64'h0);
        step();
        chk("nt1_pred", {63'd0, pred_taken}, 64'd1);
        resolve_br(64'h40, 1'b0, 64'h100, 1'b0, 64'h0);
        #1;
        chk("rbw_pred", {63'd0, pred_taken}, 64'd1);
        step();
        idle_resolve();
        chk("nt2_pred", {63'd0, pred_taken}, 64'd0);
        chk("nt2_tgt", pred_target, 64'h0);
        chk("train_nb", {32'd0, n_branch}, 64'd5);
        chk("train_nm", {32'd0, n_mispredict}, 64'd3);

        // Mispredict beats stall; stall alone holds pc
        redirect(64'h200);
        chk("prio_pc", pc, 64'h200);
        step();
        chk("hold_pc", pc, 64'h200);
        chk("prio_nm", {32'd0, n_mispredict}, 64'd4);

        // Aliasing: 0x80 evicts 0x40 from index 0
        redirect(64'h40);
        resolve_br(64'h40, 1'b1, 64'h100, 1'b1, 64'h100);
        step();
        chk("alias_pre", {63'd0, pred_taken}, 64'd1);
        resolve_br(64'h80, 1'b1, 64'h300, 1'b1, 64'h300);
        step();
        idle_resolve();
        chk("alias_post", {63'd0, pred_taken}, 64'd0);
        chk("alias_pc", pc, 64'h40);
        chk("alias_nb", {32'd0, n_branch}, 64'd7);
        chk("alias_nm", {32'd0, n_mispredict}, 64'd5);

        // Asynchronous reset between edges
        #3;
        reset = 1'b0;
        #1;
        chk("arst_pc", pc, 64'h0);
        chk("arst_nb", {32'd0, n_branch}, 64'd0);
        chk("arst_nm", {32'd0, n_mispredict}, 64'd0);
        chk("arst_pred", {63'd0, pred_taken}, 64'd0);
        chk("arst_pc2", {56'd0, pc2}, 64'hFC);
        stall = 1'b0;
        reset = 1'b1;
        step();
        chk("resume_pc", pc, 64'h4);
        chk("resume_pc2", {56'd0, pc2}, 64'h00);

        // Narrow instance: resolve_pc+4 wraps, counters saturate at 3
        rv2 = 1'b1; rib2 = 1'b0; rt2 = 1'b0; rpt2 = 1'b1; rpc2 = 8'hFC;
        #1;
        chk("wrap_flush2", {63'd0, flush2}, 64'd1);
        step();
        chk("wrap_rpc2", {56'd0, pc2}, 64'h00);
        chk("wrap_nm2", {62'd0, n_mispredict2}, 64'd1);
        rib2 = 1'b1; rpt2 = 1'b0; rpc2 = 8'h10;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("sat_nb2", {62'd0, n_branch2}, (i < 3) ? 64'(i) : 64'd3);
        end
        rv2 = 1'b0; rib2 = 1'b0;
        chk("sat_nm2", {62'd0, n_mispredict2}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
